alu_bit_sequencer: RTL

Bit-serial arithmetic/logic unit: accepts a parallel WIDTH-bit operand pair plus function select, evaluates one bit slice per clock LSB-first with a registered carry, and presents the parallel result, per-bit carries and final carry-out. It is the serialized counterpart of the team's combinational ripple ALU and uses the same S/M/Pin function encoding. It sits between the control sequencer, which issues start, and the register file or accumulator, which consumes r on done.

---
 rtl/alu_bit_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_bit_sequencer.sv
// Bit-serial ALU: one S/M/Pin slice per clock, LSB first, with a registered carry.
// Results land in r/p/cout only on entry to DONE, so partial results are never visible.

module alu_bit_slice (
  input  logic       i_a,
  input  logic       i_b,
  input  logic [3:0] i_s,
  input  logic       i_m,
  input  logic       i_c,
  output logic       o_r,
  output logic       o_c
);
  logic w_x, w_y, w_c;

  assign w_x = i_a | (i_b & i_s[0]) | (~i_b & i_s[1]);
  assign w_y = (i_a & i_b & i_s[3]) | (i_a & ~i_b & i_s[2]);
  // Logic mode kills the carry path entirely.
  assign w_c = i_c & ~i_m;
  assign o_r = w_x ^ w_y ^ w_c;
  assign o_c = ~i_m & ((w_x & w_y) | (w_x & w_c) | (w_y & w_c));
endmodule

module alu_bit_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_s,
  input  logic             i_m,
  input  logic             i_pin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_r,
  output logic [WIDTH-1:0] o_p,
  output logic             o_cout
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b;
  logic [3:0]       r_s;
  logic             r_m;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_sh_r, r_sh_p;
  logic [WIDTH-1:0] r_r, r_p;

  logic             w_accept, w_last;
  logic             w_bit_r, w_bit_c;
  logic [WIDTH-1:0] w_sh_r, w_sh_p;

  alu_bit_slice u_slice (
    .i_a (r_a[r_idx]),
    .i_b (r_b[r_idx]),
    .i_s (r_s),
    .i_m (r_m),
    .i_c (r_carry),
    .o_r (w_bit_r),
    .o_c (w_bit_c)
  );

  assign w_last = (r_idx == IW'(WIDTH - 1));

  always_comb begin
    w_accept    = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_accept    = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: if (w_last) w_state_nxt = S_DONE;
      S_DONE: begin
        w_accept    = i_start;
        w_state_nxt = i_start ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shadow with the current slice merged in, so the last bit reaches r on the same edge.
  always_comb begin
    w_sh_r        = r_sh_r;
    w_sh_p        = r_sh_p;
    w_sh_r[r_idx] = w_bit_r;
    w_sh_p[r_idx] = w_bit_c;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_m     <= 1'b0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sh_r  <= '0;
      r_sh_p  <= '0;
      r_r     <= '0;
      r_p     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a     <= i_a;
        r_b     <= i_b;
        r_s     <= i_s;
        r_m     <= i_m;
        r_idx   <= '0;
        r_carry <= i_pin & ~i_m;
      end else if (r_state == S_RUN) begin
        r_sh_r  <= w_sh_r;
        r_sh_p  <= w_sh_p;
        r_carry <= w_bit_c;
        if (w_last) begin
          r_idx <= '0;
          r_r   <= w_sh_r;
          r_p   <= w_sh_p;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign o_busy = (r_state == S_RUN);
  assign o_done = (r_state == S_DONE);
  assign o_r    = r_r;
  assign o_p    = r_p;
  assign o_cout = r_p[WIDTH-1];
endmodule
